i2c_req_arbiter: RTL

Round-robin arbiter and sequencer that shares the single I2C master between up to `NUM_REQ` on-chip requesters. Each requester posts a one-byte write transaction (7-bit address + 8-bit data) over a valid/ready handshake. The block serialises accepted transactions onto the master's command interface, waits for completion, and returns a per-requester completion pulse with an error flag for NACK or timeout. It sits directly in front of `i2c_master` in the I2C top level.

---
 rtl/i2c_req_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one I2C master between NUM_REQ requesters,
// serialising one-byte write transactions and returning per-requester responses.
module i2c_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4095
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   m_start,
    output logic [6:0]             m_addr,
    output logic [7:0]             m_data,
    input  logic                   m_busy,
    input  logic                   m_done,
    input  logic                   m_nack,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic                   rsp_err,
    output logic [2:0]             grant_id,
    output logic                   busy
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP
    } state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT);
    localparam logic [2:0]  LAST = 3'(NUM_REQ - 1);

    state_t      state;
    logic [2:0]  ptr;
    logic [15:0] cnt;
    logic [7:0]  valid_ext;
    logic [3:0]  sum;
    logic        found;
    logic [2:0]  winner;
    logic [6:0]  sel_addr;
    logic [7:0]  sel_data;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [2:0] idx);
        logic [NUM_REQ-1:0] v;
        for (int i = 0; i < NUM_REQ; i++) v[i] = (3'(i) == idx);
        return v;
    endfunction

    assign valid_ext = 8'(req_valid);

    // Search starts at ptr and wraps; the first pending requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + 4'(k);
            if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
            if (!found && valid_ext[sum[2:0]]) begin
                found  = 1'b1;
                winner = sum[2:0];
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == winner) begin
                sel_addr = req_addr[7*i +: 7];
                sel_data = req_data[8*i +: 8];
            end
        end
    end

    assign req_ready = (state == IDLE && found && !reset) ? onehot(winner) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            m_start   <= 1'b0;
            m_addr    <= '0;
            m_data    <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            grant_id  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        m_addr   <= sel_addr;
                        m_data   <= sel_data;
                        grant_id <= winner;
                        m_start  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_start <= 1'b0;
                    cnt     <= '0;
                    state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A same-cycle done wins over busy so a fast master is not missed.
                    if (m_done) begin
                        rsp_err   <= m_nack;
                        rsp_valid <= onehot(grant_id);
                        state     <= RESP;
                    end else if (m_busy) begin
                        cnt   <= '0;
                        state <= WAIT_DONE;
                    end else if (cnt == TMO) begin
                        rsp_err   <= 1'b1;
                        rsp_valid <= onehot(grant_id);
                        state     <= RESP;
                    end else if (cnt != 16'hFFFF) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_DONE: begin
                    if (m_done) begin
                        rsp_err   <= m_nack;
                        rsp_valid <= onehot(grant_id);
                        state     <= RESP;
                    end else if (cnt == TMO) begin
                        rsp_err   <= 1'b1;
                        rsp_valid <= onehot(grant_id);
                        state     <= RESP;
                    end else if (cnt != 16'hFFFF) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    rsp_err   <= 1'b0;
                    busy      <= 1'b0;
                    ptr       <= (grant_id == LAST) ? 3'd0 : grant_id + 3'd1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
